mem_bus_dma: RTL and testbench

// - Word-copy DMA engine acting as a second initiator on the SoC native memory bus (mem_valid/mem_ready

---
 rtl/mem_bus_dma.sv | 158 +++++++++++++++
 tb/tb_mem_bus_dma.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_dma.sv
// Word-copy DMA initiator on the native mem_valid/mem_ready bus: reads cfg_len words from cfg_src, writes them to cfg_dst.
// Optional fill mode (writes cfg_fill_data, no reads) is enabled by defining MEM_DMA_FILL_EN.
module mem_bus_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [31:0]         cfg_src,
  input  logic [31:0]         cfg_dst,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                cfg_fill,
  input  logic [31:0]         cfg_fill_data,
  output logic                busy,
  output logic                done,
  output logic [LEN_BITS-1:0] xfer_count,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, GAP_W, WR, GAP_R, DONE} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         src_reg, src_next;
  logic [31:0]         dst_reg, dst_next;
  logic [31:0]         data_reg, data_next;
  logic [LEN_BITS-1:0] len_reg, len_next;
  logic [LEN_BITS-1:0] count_reg, count_next;
  logic                abort_reg, abort_next;
  logic                fill_reg, fill_next;
  logic                abort_now;
  logic                last_beat;
  logic                fill_sel;
  logic [31:0]         fill_word;
  logic                unused_addr_bits;

`ifdef MEM_DMA_FILL_EN
  assign fill_sel  = cfg_fill;
  assign fill_word = cfg_fill_data;
`else
  logic unused_fill;
  assign fill_sel    = 1'b0;
  assign fill_word   = 32'h0;
  assign unused_fill = ^{cfg_fill, cfg_fill_data};
`endif

  // Byte-offset bits are dropped; every access is a whole word.
  assign unused_addr_bits = ^{cfg_src[1:0], cfg_dst[1:0]};

  assign mem_instr  = 1'b0;
  assign xfer_count = count_reg;

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    data_next  = data_reg;
    len_next   = len_reg;
    count_next = count_reg;
    fill_next  = fill_reg;
    abort_now  = abort_reg | cfg_abort;
    abort_next = abort_now;
    last_beat  = (count_reg + LEN_BITS'(1)) == len_reg;

    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        if (cfg_start) begin
          src_next   = {cfg_src[31:2], 2'b00};
          dst_next   = {cfg_dst[31:2], 2'b00};
          len_next   = cfg_len;
          count_next = '0;
          fill_next  = fill_sel;
          data_next  = fill_word;
          if (cfg_len == '0)
            state_next = DONE;
          else if (fill_sel)
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD: begin
        if (mem_ready) begin
          data_next  = mem_rdata;
          src_next   = src_reg + 32'd4;
          // An abort seen during the read drops the word rather than writing it.
          state_next = abort_now ? DONE : GAP_W;
        end
      end
      GAP_W: state_next = abort_now ? DONE : WR;
      WR: begin
        if (mem_ready) begin
          dst_next   = dst_reg + 32'd4;
          count_next = count_reg + LEN_BITS'(1);
          state_next = (last_beat || abort_now) ? DONE : GAP_R;
        end
      end
      GAP_R: begin
        if (abort_now)
          state_next = DONE;
        else
          state_next = fill_reg ? WR : RD;
      end
      DONE: begin
        abort_next = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so a request appears the cycle after the decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      data_reg  <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      abort_reg <= 1'b0;
      fill_reg  <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      data_reg  <= data_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      abort_reg <= abort_next;
      fill_reg  <= fill_next;
      mem_valid <= (state_next == RD) || (state_next == WR);
      mem_wstrb <= (state_next == WR) ? 4'hf : 4'h0;
      if (state_next == RD)
        mem_addr <= src_next;
      else if (state_next == WR)
        mem_addr <= dst_next;
      if (state_next == WR)
        mem_wdata <= data_next;
      busy      <= state_next != IDLE;
      done      <= state_next == DONE;
    end
  end

endmodule

// File: tb/tb_mem_bus_dma.sv
// Directed bench for mem_bus_dma: a queue of expected bus transactions is checked every valid cycle,
// and per-test completion timing and counts are checked against hand-computed values.
module tb_mem_bus_dma;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [31:0]   cfg_src = '0;
  logic [31:0]   cfg_dst = '0;
  logic [LB-1:0] cfg_len = '0;
  logic          cfg_fill = 1'b0;
  logic [31:0]   cfg_fill_data = '0;
  logic          busy, done, mem_valid, mem_instr;
  logic [LB-1:0] xfer_count;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;

  mem_bus_dma #(.LEN_BITS(LB)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_fill(cfg_fill), .cfg_fill_data(cfg_fill_data),
    .busy(busy), .done(done), .xfer_count(xfer_count),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_addr_log[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hc0de, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Responder: memory content is a pure function of address, ready after wait_cycles extra cycles.
  int wait_cycles = 0;
  int wcnt = 0;
  assign mem_rdata = (mem_valid && mem_ready && mem_wstrb == 4'h0) ? init_word(mem_addr) : 32'hbad0bad0;

  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end else if (mem_valid && !mem_ready) begin
      if (wcnt >= wait_cycles) begin
        mem_ready <= 1'b1;
        wcnt      <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end
  end

  // Compare process: every valid cycle must match the head of the expected queue.
  bit had_hs = 0;
  bit prev_valid = 0;
  int low_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      had_hs     = 0;
      prev_valid = 0;
      low_cnt    = 0;
    end else begin
      if (mem_valid) begin
        check("instr", {31'd0, mem_instr}, 32'd0);
        check("busy_with_valid", {31'd0, busy}, 32'd1);
        if (!prev_valid && had_hs) check("gap_len", low_cnt, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h wstrb %h expected no request", mem_addr, mem_wstrb);
        end else begin
          check("addr", mem_addr, exp_q[0].addr);
          check("wstrb", {28'd0, mem_wstrb}, {28'd0, exp_q[0].wstrb});
          if (exp_q[0].wstrb == 4'hf) check("wdata", mem_wdata, exp_q[0].wdata);
          if (mem_ready) begin
            if (mem_wstrb == 4'hf) begin
              $display("%0t WR addr=%h data=%h", $time, mem_addr, mem_wdata);
              wr_addr_log.push_back(mem_addr);
              wr_data_log.push_back(mem_wdata);
            end else begin
              $display("%0t RD addr=%h data=%h", $time, mem_addr, mem_rdata);
              rd_addr_log.push_back(mem_addr);
            end
            void'(exp_q.pop_front());
          end
        end
        if (mem_ready) begin
          had_hs  = 1;
          low_cnt = 0;
        end
      end else begin
        low_cnt++;
      end
      if (done) had_hs = 0;
      prev_valid = mem_valid;
    end
  end

  task automatic exp_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{s + 32'(4 * i), 4'h0, 32'h0});
      exp_q.push_back('{d + 32'(4 * i), 4'hf, init_word(s + 32'(4 * i))});
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_addr_log.delete();
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [LB-1:0] n,
                       input logic f, input logic [31:0] fd);
    @(negedge clk);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_fill = f; cfg_fill_data = fd;
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the edge that sampled cfg_start.
  task automatic wait_done(output int dcyc, output int bcnt, output int lastwr, output int firstv);
    dcyc = -1; bcnt = 0; lastwr = -1; firstv = 0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (mem_valid && firstv == 0) firstv = cyc;
      if (mem_valid && mem_ready && mem_wstrb == 4'hf) lastwr = cyc;
      if (done) begin
        dcyc = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected done within 500 cycles");
  endtask

  task automatic wait_until_rd_or_wr(input bit want_wr, input int cnt);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_valid && (mem_wstrb == (want_wr ? 4'hf : 4'h0)) && (int'(xfer_count) == cnt)) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_timeout: got no matching request expected one within 200 cycles");
  endtask

  int dcyc, bcnt, lastwr, firstv, seen_done;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_count", {16'd0, xfer_count}, 32'd0);
    reset = 1'b0;

    // Copy 4 words, single-cycle responder
    wait_cycles = 0;
    clear_logs();
    exp_copy(32'h100, 32'h200, 4);
    start(32'h100, 32'h200, 16'd4, 1'b0, 32'h0);
    wait_done(dcyc, bcnt, lastwr, firstv);
    check("copy_first_valid", firstv, 1);
    check("copy_done_cycle", dcyc, 24);
    check("copy_busy_cycles", bcnt, 24);
    check("copy_done_after_wr", dcyc, lastwr + 1);
    check("copy_count", {16'd0, xfer_count}, 32'd4);
    check("copy_pending", exp_q.size(), 0);
    check("copy_rd0_addr", (rd_addr_log.size() > 0) ? rd_addr_log[0] : 32'hffffffff, 32'h100);
    check("copy_wr3_addr", (wr_addr_log.size() > 3) ? wr_addr_log[3] : 32'hffffffff, 32'h20c);
    check("copy_wr3_data", (wr_data_log.size() > 3) ? wr_data_log[3] : 32'hffffffff, 32'hc0de010c);
    @(negedge clk);
    check("copy_done_pulse", {31'd0, done}, 32'd0);
    check("copy_idle_busy", {31'd0, busy}, 32'd0);

    // Zero-length start
    start(32'h500, 32'h600, 16'd0, 1'b0, 32'h0);
    wait_done(dcyc, bcnt, lastwr, firstv);
    check("len0_done_cycle", dcyc, 1);
    check("len0_no_valid", firstv, 0);
    check("len0_count", {16'd0, xfer_count}, 32'd0);
    check("len0_busy_cycles", bcnt, 1);

    // Three wait states per beat
    wait_cycles = 3;
    clear_logs();
    exp_copy(32'h180, 32'h280, 2);
    start(32'h180, 32'h280, 16'd2, 1'b0, 32'h0);
    wait_done(dcyc, bcnt, lastwr, firstv);
    check("wait_done_cycle", dcyc, 24);
    check("wait_count", {16'd0, xfer_count}, 32'd2);
    check("wait_pending", exp_q.size(), 0);

    // Abort during the second write of an 8-word copy
    wait_cycles = 0;
    clear_logs();
    exp_copy(32'h300, 32'h380, 2);
    start(32'h300, 32'h380, 16'd8, 1'b0, 32'h0);
    wait_until_rd_or_wr(1'b1, 1);
    cfg_abort = 1'b1;
    @(posedge clk);
    #1 cfg_abort = 1'b0;
    wait_done(dcyc, bcnt, lastwr, firstv);
    check("abort_done_after_wr", dcyc, lastwr + 1);
    check("abort_count", {16'd0, xfer_count}, 32'd2);
    check("abort_pending", exp_q.size(), 0);
    check("abort_last_addr", (wr_addr_log.size() > 1) ? wr_addr_log[wr_addr_log.size() - 1] : 32'hffffffff, 32'h384);

    // Reset while a read is outstanding, then a fresh transfer
    clear_logs();
    exp_copy(32'h100, 32'h200, 4);
    start(32'h100, 32'h200, 16'd4, 1'b0, 32'h0);
    wait_until_rd_or_wr(1'b0, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("rst_mid_no_done", seen_done, 0);
    reset = 1'b0;
    clear_logs();
    exp_copy(32'h140, 32'h240, 1);
    start(32'h140, 32'h240, 16'd1, 1'b0, 32'h0);
    wait_done(dcyc, bcnt, lastwr, firstv);
    check("restart_done_cycle", dcyc, 6);
    check("restart_count", {16'd0, xfer_count}, 32'd1);
    check("restart_data", (wr_data_log.size() > 0) ? wr_data_log[0] : 32'hffffffff, 32'hc0de0140);
    check("restart_pending", exp_q.size(), 0);

`ifdef MEM_DMA_FILL_EN
    // Fill with wrap past the top of the address space
    clear_logs();
    exp_q.push_back('{32'hfffffff8, 4'hf, 32'hdeadbeef});
    exp_q.push_back('{32'hfffffffc, 4'hf, 32'hdeadbeef});
    exp_q.push_back('{32'h00000000, 4'hf, 32'hdeadbeef});
    start(32'h0, 32'hfffffff8, 16'd3, 1'b1, 32'hdeadbeef);
    wait_done(dcyc, bcnt, lastwr, firstv);
    check("fill_done_cycle", dcyc, 9);
    check("fill_count", {16'd0, xfer_count}, 32'd3);
    check("fill_no_reads", rd_addr_log.size(), 0);
    check("fill_wrap_addr", (wr_addr_log.size() > 2) ? wr_addr_log[2] : 32'hffffffff, 32'h0);
    check("fill_pending", exp_q.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
